// File: rtl/arcade_ram_bridge.sv
// arcade_ram_bridge: connects an arcade card's byte-wide CPU RAM port to a
// request/acknowledge memory controller. Writes are posted through a
// one-entry buffer. Reads go through a one-entry cache. Every memory request
// has a timeout, so a controller that stops answering cannot hang the CPU.
module arcade_ram_bridge #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CS_N,
    input  logic        RD_N,
    input  logic        WR_N,
    input  logic [20:0] A,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    output logic        BUSY,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [20:0] MEM_ADDR,
    output logic [7:0]  MEM_DIN,
    input  logic [7:0]  MEM_DOUT,
    input  logic        MEM_ACK,
    output logic        ERR
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, WPOST, RFETCH, WAITWR} state_t;

    state_t        state_reg;
    logic          strobe_d_reg;
    logic [CW-1:0] tmo_cnt_reg;
    logic          cache_valid_reg;
    logic [20:0]   cache_tag_reg;
    logic [7:0]    cache_data_reg;
    logic [20:0]   rd_addr_reg;
    logic          pend_valid_reg;
    logic [20:0]   pend_addr_reg;
    logic [7:0]    pend_data_reg;

    logic strobe;
    logic start;
    logic start_wr;
    logic start_rd;
    logic hit;
    logic pend_hit;
    logic tmo_expire;

    // An access starts on the falling edge of either strobe while the card
    // RAM is selected. Strobes that are held low do not start a new access.
    assign strobe     = ~(RD_N & WR_N);
    assign start      = strobe & ~strobe_d_reg & ~CS_N;
    assign start_wr   = start & ~WR_N;
    assign start_rd   = start & WR_N & ~RD_N;
    assign hit        = cache_valid_reg && (cache_tag_reg == A);
    assign pend_hit   = cache_valid_reg && (cache_tag_reg == pend_addr_reg);
    assign tmo_expire = MEM_REQ && !MEM_ACK && (tmo_cnt_reg == CW'(TIMEOUT_CYC - 1));

    // Remember the previous strobe level so that start detection is edge-based
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) strobe_d_reg <= 1'b0;
        else        strobe_d_reg <= strobe;
    end

    // Main controller: write buffer, read cache, memory handshake and timeout
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg       <= IDLE;
            MEM_REQ         <= 1'b0;
            MEM_WE          <= 1'b0;
            MEM_ADDR        <= '0;
            MEM_DIN         <= '0;
            DO              <= 8'hFF;
            BUSY            <= 1'b0;
            ERR             <= 1'b0;
            tmo_cnt_reg     <= '0;
            cache_valid_reg <= 1'b0;
            cache_tag_reg   <= '0;
            cache_data_reg  <= '0;
            rd_addr_reg     <= '0;
            pend_valid_reg  <= 1'b0;
            pend_addr_reg   <= '0;
            pend_data_reg   <= '0;
        end else if (tmo_expire) begin
            // Give up on the request and release the CPU. The cache is
            // invalidated because its contents can no longer be trusted.
            MEM_REQ         <= 1'b0;
            MEM_WE          <= 1'b0;
            ERR             <= 1'b1;
            cache_valid_reg <= 1'b0;
            DO              <= 8'hFF;
            BUSY            <= 1'b0;
            pend_valid_reg  <= 1'b0;
            tmo_cnt_reg     <= tmo_cnt_reg + CW'(1);
            state_reg       <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A stray MEM_ACK arriving here is ignored
                    if (start_wr) begin
                        MEM_ADDR    <= A;
                        MEM_DIN     <= DI;
                        MEM_REQ     <= 1'b1;
                        MEM_WE      <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= WPOST;
                        if (hit) cache_data_reg <= DI;
                    end else if (start_rd) begin
                        if (hit) begin
                            DO <= cache_data_reg;
                        end else begin
                            DO          <= 8'hFF;
                            BUSY        <= 1'b1;
                            MEM_ADDR    <= A;
                            rd_addr_reg <= A;
                            MEM_REQ     <= 1'b1;
                            MEM_WE      <= 1'b0;
                            tmo_cnt_reg <= '0;
                            state_reg   <= RFETCH;
                        end
                    end
                end
                WPOST: begin
                    if (MEM_ACK) begin
                        // The buffered write retires here. A stalled write, or
                        // one that starts in this same cycle, refills the
                        // buffer immediately.
                        tmo_cnt_reg <= '0;
                        if (pend_valid_reg) begin
                            MEM_ADDR       <= pend_addr_reg;
                            MEM_DIN        <= pend_data_reg;
                            pend_valid_reg <= 1'b0;
                            BUSY           <= 1'b0;
                            if (pend_hit) cache_data_reg <= pend_data_reg;
                        end else if (start_wr) begin
                            MEM_ADDR <= A;
                            MEM_DIN  <= DI;
                            if (hit) cache_data_reg <= DI;
                        end else if (start_rd) begin
                            DO          <= 8'hFF;
                            BUSY        <= 1'b1;
                            MEM_ADDR    <= A;
                            rd_addr_reg <= A;
                            MEM_WE      <= 1'b0;
                            state_reg   <= RFETCH;
                        end else begin
                            MEM_REQ   <= 1'b0;
                            MEM_WE    <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
                        if (start_wr && !pend_valid_reg) begin
                            // The buffer is full, so stall the CPU and hold
                            // the new write until the buffer drains.
                            pend_valid_reg <= 1'b1;
                            pend_addr_reg  <= A;
                            pend_data_reg  <= DI;
                            BUSY           <= 1'b1;
                        end else if (start_rd && !pend_valid_reg) begin
                            // The read must not pass the posted write
                            DO          <= 8'hFF;
                            BUSY        <= 1'b1;
                            rd_addr_reg <= A;
                            state_reg   <= WAITWR;
                        end
                    end
                end
                WAITWR: begin
                    // MEM_REQ stays high; it carries straight on into the fetch
                    if (MEM_ACK) begin
                        MEM_ADDR    <= rd_addr_reg;
                        MEM_WE      <= 1'b0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= RFETCH;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
                    end
                end
                RFETCH: begin
                    if (MEM_ACK) begin
                        DO              <= MEM_DOUT;
                        cache_data_reg  <= MEM_DOUT;
                        cache_tag_reg   <= rd_addr_reg;
                        cache_valid_reg <= 1'b1;
                        BUSY            <= 1'b0;
                        MEM_REQ         <= 1'b0;
                        state_reg       <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arcade_ram_bridge.sv
// Testbench for arcade_ram_bridge. A vector table drives CPU accesses while a
// behavioural memory controller responds after a programmable delay. Hand
// sequences cover reset values and asynchronous reset in the middle of a fetch.
module tb_arcade_ram_bridge;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CS_N = 1'b1;
    logic        RD_N = 1'b1;
    logic        WR_N = 1'b1;
    logic [20:0] A = '0;
    logic [7:0]  DI = '0;
    logic [7:0]  DO;
    logic        BUSY;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [20:0] MEM_ADDR;
    logic [7:0]  MEM_DIN;
    logic [7:0]  MEM_DOUT = '0;
    logic        MEM_ACK = 1'b0;
    logic        ERR;

    arcade_ram_bridge #(.TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
        .A(A), .DI(DI), .DO(DO), .BUSY(BUSY), .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT), .MEM_ACK(MEM_ACK), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Memory controller model: the bench writes ack_delay, resp_data and
    // stray_cnt. The responder writes everything else.
    int          ack_delay = -1;
    logic [7:0]  resp_data = '0;
    int          stray_cnt = 0;
    int          stray_seen = 0;
    int          age = 0;
    int          log_n = 0;
    logic        log_we   [64];
    logic [20:0] log_addr [64];
    logic [7:0]  log_din  [64];

    // The model acts 1 ns after each rising edge, so it sees stable outputs
    always @(posedge CLK) begin
        #1;
        if (MEM_ACK) begin
            MEM_ACK = 1'b0;
        end else if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            MEM_DOUT   = 8'h99;
            MEM_ACK    = 1'b1;
        end else if (MEM_REQ && ack_delay >= 0) begin
            if (age == ack_delay) begin
                MEM_ACK  = 1'b1;
                MEM_DOUT = resp_data;
                if (log_n < 64) begin
                    log_we[log_n]   = MEM_WE;
                    log_addr[log_n] = MEM_ADDR;
                    log_din[log_n]  = MEM_DIN;
                end
                log_n = log_n + 1;
                age   = 0;
            end else begin
                age = age + 1;
            end
        end else begin
            age = 0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [20:0] addr;
        logic [7:0]  data;    // DI for a write, memory response for a read
        int          dly;     // ack delay, -1 = memory never answers
        bit          drain;   // wait for the memory request to finish
        int          busy;    // expected cycles with BUSY high
        logic [7:0]  dout;    // expected DO (reads only)
        int          reqs;    // expected memory requests, -1 = skip
        bit          f_we;
        logic [20:0] f_addr;
        logic [7:0]  f_din;
        bit          l_we;
        logic [20:0] l_addr;
        logic [7:0]  l_din;
        int          reqcyc;  // expected cycles with MEM_REQ high, -1 = skip
        bit          err;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int busy_n;
        int req_n;
        int log0;
        bit stuck;
        logic [7:0] do_s;
        @(negedge CLK);
        log0      = log_n;
        ack_delay = v.dly;
        resp_data = v.data;
        A         = v.addr;
        DI        = v.data;
        CS_N      = 1'b0;
        if (v.wr) WR_N = 1'b0;
        else      RD_N = 1'b0;
        busy_n = 0;
        req_n  = 0;
        stuck  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (MEM_REQ) req_n++;
            if (BUSY) busy_n++;
            else begin
                stuck = 1'b0;
                break;
            end
        end
        do_s = DO;
        RD_N = 1'b1;
        WR_N = 1'b1;
        CS_N = 1'b1;
        if (v.drain) begin
            for (int i = 0; i < 300 && MEM_REQ; i++) begin
                @(negedge CLK);
                if (MEM_REQ) req_n++;
            end
            chk($sformatf("v%0d req_drain", idx), {31'd0, MEM_REQ}, 32'd0);
        end
        chk($sformatf("v%0d busy_bound", idx), {31'd0, stuck}, 32'd0);
        chk($sformatf("v%0d busy_cycles", idx), busy_n, v.busy);
        if (!v.wr) chk($sformatf("v%0d DO", idx), {24'd0, do_s}, {24'd0, v.dout});
        chk($sformatf("v%0d ERR", idx), {31'd0, ERR}, {31'd0, v.err});
        if (v.reqcyc >= 0) chk($sformatf("v%0d req_cycles", idx), req_n, v.reqcyc);
        if (v.reqs >= 0) begin
            chk($sformatf("v%0d mem_reqs", idx), log_n - log0, v.reqs);
            if (v.reqs > 0 && log_n - log0 == v.reqs) begin
                chk($sformatf("v%0d first_we", idx), {31'd0, log_we[log0]}, {31'd0, v.f_we});
                chk($sformatf("v%0d first_addr", idx), {11'd0, log_addr[log0]}, {11'd0, v.f_addr});
                if (v.f_we) chk($sformatf("v%0d first_din", idx), {24'd0, log_din[log0]}, {24'd0, v.f_din});
                chk($sformatf("v%0d last_we", idx), {31'd0, log_we[log_n-1]}, {31'd0, v.l_we});
                chk($sformatf("v%0d last_addr", idx), {11'd0, log_addr[log_n-1]}, {11'd0, v.l_addr});
                if (v.l_we) chk($sformatf("v%0d last_din", idx), {24'd0, log_din[log_n-1]}, {24'd0, v.l_din});
            end
        end
        $display("[TB] v%0d %s addr=%06h data=%02h busy=%0d DO=%02h", idx,
                 v.wr ? "WR" : "RD", v.addr, v.data, busy_n, do_s);
    endtask

    vec_t vecs [18];
    vec_t post_rst;

    initial begin
        //          wr  addr       data  dly drn busy dout  reqs fwe faddr      fdin  lwe laddr      ldin rcyc err
        vecs[0]  = '{0, 21'h012345, 8'h5A, 5, 1, 6, 8'h5A, 1, 0, 21'h012345, 8'h00, 0, 21'h012345, 8'h00, -1, 0};
        vecs[1]  = '{0, 21'h012345, 8'h00, 5, 1, 0, 8'h5A, 0, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[2]  = '{1, 21'h012345, 8'hA7, 2, 1, 0, 8'h00, 1, 1, 21'h012345, 8'hA7, 1, 21'h012345, 8'hA7, -1, 0};
        vecs[3]  = '{0, 21'h012345, 8'h00, 2, 1, 0, 8'hA7, 0, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[4]  = '{1, 21'h000010, 8'h11, 3, 0, 0, 8'h00,-1, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[5]  = '{0, 21'h000020, 8'h33, 3, 1, 7, 8'h33, 2, 1, 21'h000010, 8'h11, 0, 21'h000020, 8'h00, -1, 0};
        vecs[6]  = '{0, 21'h1FFFFF, 8'hC3, 1, 1, 2, 8'hC3, 1, 0, 21'h1FFFFF, 8'h00, 0, 21'h1FFFFF, 8'h00, -1, 0};
        vecs[7]  = '{0, 21'h000000, 8'h3C, 0, 1, 1, 8'h3C, 1, 0, 21'h000000, 8'h00, 0, 21'h000000, 8'h00, -1, 0};
        vecs[8]  = '{0, 21'h000000, 8'h00, 0, 1, 0, 8'h3C, 0, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[9]  = '{1, 21'h000000, 8'h5F, 0, 1, 0, 8'h00, 1, 1, 21'h000000, 8'h5F, 1, 21'h000000, 8'h5F, -1, 0};
        vecs[10] = '{0, 21'h000000, 8'h00, 0, 1, 0, 8'h5F, 0, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[11] = '{1, 21'h000100, 8'h01, 1, 0, 0, 8'h00,-1, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[12] = '{1, 21'h000101, 8'h02, 1, 1, 0, 8'h00, 1, 1, 21'h000101, 8'h02, 1, 21'h000101, 8'h02, -1, 0};
        vecs[13] = '{1, 21'h000200, 8'h21, 4, 0, 0, 8'h00,-1, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[14] = '{1, 21'h000201, 8'h22, 4, 1, 3, 8'h00, 2, 1, 21'h000200, 8'h21, 1, 21'h000201, 8'h22, -1, 0};
        vecs[15] = '{0, 21'h000000, 8'h00, 0, 1, 0, 8'h5F, 0, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00, -1, 0};
        vecs[16] = '{0, 21'h000777, 8'h00,-1, 1, 8, 8'hFF, 0, 0, 21'h0,      8'h00, 0, 21'h0,      8'h00,  8, 1};
        vecs[17] = '{0, 21'h000000, 8'h44, 0, 1, 1, 8'h44, 1, 0, 21'h000000, 8'h00, 0, 21'h000000, 8'h00, -1, 1};
        post_rst = '{0, 21'h000000, 8'h77, 0, 1, 1, 8'h77, 1, 0, 21'h000000, 8'h00, 0, 21'h000000, 8'h00, -1, 0};

        // Values held while in reset
        repeat (3) @(negedge CLK);
        chk("rst DO", {24'd0, DO}, 32'hFF);
        chk("rst BUSY", {31'd0, BUSY}, 32'd0);
        chk("rst MEM_REQ", {31'd0, MEM_REQ}, 32'd0);
        chk("rst MEM_WE", {31'd0, MEM_WE}, 32'd0);
        chk("rst MEM_ADDR", {11'd0, MEM_ADDR}, 32'd0);
        chk("rst MEM_DIN", {24'd0, MEM_DIN}, 32'd0);
        chk("rst ERR", {31'd0, ERR}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // Asynchronous reset while a read fetch is outstanding
        @(negedge CLK);
        ack_delay = -1;
        A    = 21'h000888;
        CS_N = 1'b0;
        RD_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("fetch MEM_REQ", {31'd0, MEM_REQ}, 32'd1);
        chk("fetch BUSY", {31'd0, BUSY}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst MEM_REQ", {31'd0, MEM_REQ}, 32'd0);
        chk("arst BUSY", {31'd0, BUSY}, 32'd0);
        chk("arst DO", {24'd0, DO}, 32'hFF);
        chk("arst ERR", {31'd0, ERR}, 32'd0);
        chk("arst MEM_ADDR", {11'd0, MEM_ADDR}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        RD_N  = 1'b1;
        CS_N  = 1'b1;
        @(negedge CLK);
        stray_cnt = stray_cnt + 1;
        repeat (3) @(negedge CLK);
        chk("stray MEM_REQ", {31'd0, MEM_REQ}, 32'd0);
        chk("stray BUSY", {31'd0, BUSY}, 32'd0);
        chk("stray DO", {24'd0, DO}, 32'hFF);
        chk("stray ERR", {31'd0, ERR}, 32'd0);
        $display("[TB] reset during fetch, stray ack issued");
        run_vec(18, post_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
